alu_16bit_seq: RTL

ALU_16BIT_SEQ -- requirements
Module: alu_16bit_seq

---
 rtl/alu_16bit_seq.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/alu_16bit_seq.sv
// Sequential controller for an external 16-bit ALU: accepts one request, steps the ALU
// through one or two cycles (two for signed set-less-than) and holds the response until it is taken.
module alu_16bit_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [2:0]  op_code,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic        res_zero,
  output logic        res_carry,
  output logic        res_ovf,
  output logic        res_err,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic        alu_cin,
  output logic        alu_binv,
  output logic        alu_sel1,
  output logic        alu_sel0,
  output logic [15:0] alu_less,
  input  logic [15:0] alu_result,
  input  logic        alu_co
);

  typedef enum logic [1:0] {IDLE, EXEC, SLT2, DONE} state_t;
  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b110,
    OP_SLT = 3'b111
  } op_t;

  state_t      state;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic [2:0]  op_q;
  logic        lt;

  logic        is_slt;
  logic        is_addsub;
  logic        is_legal;
  logic        ovf;

  always_comb begin
    is_slt    = (op_q == OP_SLT);
    is_addsub = (op_q == OP_ADD) || (op_q == OP_SUB);
    is_legal  = is_addsub || is_slt || (op_q == OP_AND) || (op_q == OP_OR);
  end

  // ALU drives are a pure decode of the registered state and latched request.
  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_cin  = 1'b0;
    alu_binv = 1'b0;
    alu_sel1 = 1'b0;
    alu_sel0 = 1'b0;
    alu_less = '0;
    case (state)
      EXEC: begin
        alu_a = a_q;
        alu_b = b_q;
        case (op_q)
          OP_OR:  alu_sel0 = 1'b1;
          OP_ADD: alu_sel1 = 1'b1;
          OP_SUB, OP_SLT: begin
            alu_binv = 1'b1;
            alu_cin  = 1'b1;
            alu_sel1 = 1'b1;
          end
          default: ;
        endcase
      end
      SLT2: begin
        alu_a    = a_q;
        alu_b    = b_q;
        alu_binv = 1'b1;
        alu_cin  = 1'b1;
        alu_sel1 = 1'b1;
        alu_sel0 = 1'b1;
        alu_less = {15'b0, lt};
      end
      default: ;
    endcase
  end

  // Signed overflow of a + b' where b' is the operand as actually presented to the adder.
  always_comb begin
    ovf = (a_q[15] == (b_q[15] ^ alu_binv)) && (alu_result[15] != a_q[15]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      op_ready  <= 1'b1;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_zero  <= 1'b0;
      res_carry <= 1'b0;
      res_ovf   <= 1'b0;
      res_err   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      lt        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (op_valid) begin
            a_q      <= op_a;
            b_q      <= op_b;
            op_q     <= op_code;
            op_ready <= 1'b0;
            state    <= EXEC;
          end
        end
        EXEC: begin
          if (is_slt) begin
            lt    <= alu_result[15] ^ ovf;
            state <= SLT2;
          end else begin
            if (is_legal) begin
              res_data  <= alu_result;
              res_zero  <= (alu_result == '0);
              res_carry <= alu_co;
              res_ovf   <= is_addsub & ovf;
              res_err   <= 1'b0;
            end else begin
              res_data  <= '0;
              res_zero  <= 1'b0;
              res_carry <= 1'b0;
              res_ovf   <= 1'b0;
              res_err   <= 1'b1;
            end
            res_valid <= 1'b1;
            state     <= DONE;
          end
        end
        SLT2: begin
          res_data  <= alu_result;
          res_zero  <= (alu_result == '0);
          res_carry <= 1'b0;
          res_ovf   <= 1'b0;
          res_err   <= 1'b0;
          res_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            op_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
